vid_frame_sig: RTL and testbench

- Synthesizable frame-signature unit for the epochtv1 video output (CE, DE, HS, VS, RGB).
- Replaces offline dumping of rendered frames with an on-chip CRC of the active pixels, plus line/width geometry counters.
- Sits beside epochtv1 in the scv core and in benches, so render regressions compare one CRC per frame instead of a pixel dump.
- Generalised in pixel width, CRC width/polynomial, frame count and mode (single-shot N-frame or continuous).

---
 rtl/scv_pkg.sv | 20 ++
 rtl/vid_crc_step.sv | 37 +++
 rtl/vid_frame_sig.sv | 275 +++++++++++++++++++++++++++
 tb/tb_vid_frame_sig.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scv_pkg.sv
// -----------------------------------------------------------------------------
// scv_pkg
// Shared definitions for the frame-signature unit of the scv video path.
//   vfs_state_t   : capture sequencer states
//   VFS_CRC_POLY  : default 32-bit CRC polynomial (implicit top bit)
// -----------------------------------------------------------------------------
package scv_pkg;

    // Capture sequencer states. The ST_ prefix keeps the names clear of the
    // DONE output port in modules that import this package.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } vfs_state_t;

    localparam logic [31:0] VFS_CRC_POLY = 32'h04C11DB7;

endpackage : scv_pkg

// File: rtl/vid_crc_step.sv
// -----------------------------------------------------------------------------
// vid_crc_step
// Combinational, fully unrolled CRC update over one pixel word.
// Bits are consumed MSB-first, no reflection, no final XOR.
// Kept standalone so benches can reuse it as a reference model.
//   crc_in  [CRC_W] : running CRC before this pixel
//   data    [RGB_W] : pixel word (already masked by the caller)
//   crc_out [CRC_W] : CRC after all RGB_W bits of data
// -----------------------------------------------------------------------------
module vid_crc_step
    import scv_pkg::*;
#(
    parameter int                 RGB_W    = 24,
    parameter int                 CRC_W    = 32,
    parameter logic [CRC_W-1:0]   CRC_POLY = VFS_CRC_POLY
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [RGB_W-1:0] data,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] acc_s;

    // Serial CRC shift register unrolled across all data bits.
    always_comb begin
        acc_s = crc_in;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            if ((acc_s[CRC_W-1] ^ data[i]) == 1'b1) begin
                acc_s = {acc_s[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                acc_s = {acc_s[CRC_W-2:0], 1'b0};
            end
        end
        crc_out = acc_s;
    end

endmodule : vid_crc_step

// File: rtl/vid_frame_sig.sv
// -----------------------------------------------------------------------------
// vid_frame_sig
// Frame-signature unit for the epochtv1 video output. Computes a CRC over the
// active (DE) pixels of one or more frames and measures line count / width.
//   CLK, RES      : clock, synchronous active-high reset
//   CE            : pixel clock enable, video inputs valid only when high
//   DE, HS, VS    : active video, hsync (unused), vsync (rising = frame edge)
//   RGB, CH_MASK  : pixel data and per-bit include mask
//   MODE          : 0 single-shot over NFRAMES frames, 1 continuous
//   ARM           : one-CLK start/restart pulse
//   NFRAMES       : frame count for single-shot (0 behaves as 1)
//   BUSY, DONE    : status (DONE is a level in single-shot, a pulse otherwise)
//   SIG           : latched signature
//   LINES, WIDTH  : active lines / first-line width of the last frame
//   ERR           : a line of the last frame differed from the first's width
// -----------------------------------------------------------------------------
module vid_frame_sig
    import scv_pkg::*;
#(
    parameter int               RGB_W    = 24,
    parameter int               CRC_W    = 32,
    parameter logic [CRC_W-1:0] CRC_POLY = VFS_CRC_POLY,
    parameter int               CNT_W    = 10,
    parameter int               NF_W     = 4
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             CE,
    input  logic             DE,
    input  logic             HS,
    input  logic             VS,
    input  logic [RGB_W-1:0] RGB,
    input  logic [RGB_W-1:0] CH_MASK,
    input  logic             MODE,
    input  logic             ARM,
    input  logic [NF_W-1:0]  NFRAMES,
    output logic             BUSY,
    output logic             DONE,
    output logic [CRC_W-1:0] SIG,
    output logic [CNT_W-1:0] LINES,
    output logic [CNT_W-1:0] WIDTH,
    output logic             ERR
);

    localparam logic [CRC_W-1:0] CRC_INIT = {CRC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NF_W:0]    NF_ONE   = {{NF_W{1'b0}}, 1'b1};

    // Saturating counter increment for pixel and line counts.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    vfs_state_t       state_r;
    logic             vs_q_r;
    logic             de_q_r;
    logic [CRC_W-1:0] crc_r;
    logic [CNT_W-1:0] pix_r;
    logic [CNT_W-1:0] line_r;
    logic [CNT_W-1:0] width_w_r;
    logic             width_valid_r;
    logic             err_w_r;
    logic [NF_W-1:0]  frame_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [CRC_W-1:0] sig_r;
    logic [CNT_W-1:0] lines_r;
    logic [CNT_W-1:0] width_r;
    logic             err_r;

    logic             vs_rise_s;
    logic             de_fall_s;
    logic [RGB_W-1:0] px_data_s;
    logic [CRC_W-1:0] crc_base_s;
    logic [CRC_W-1:0] crc_step_s;
    logic [CNT_W-1:0] line_n_s;
    logic [CNT_W-1:0] width_w_n_s;
    logic             width_valid_n_s;
    logic             err_w_n_s;
    logic [NF_W:0]    fc_n_s;
    logic [NF_W:0]    target_s;
    logic             last_frame_s;
    logic             unused_hs_s;

    // HS is informational only; line ends come from DE falling.
    assign unused_hs_s = HS;

    // Edge detection against the CE-sampled copies of VS and DE.
    always_comb begin
        vs_rise_s = CE & VS & ~vs_q_r;
        de_fall_s = CE & ~DE & de_q_r;
        px_data_s = RGB & CH_MASK;
    end

    // A frame start (from WAIT_VS, or every boundary in continuous mode)
    // restarts the CRC, so a pixel on that same CE folds into the fresh seed.
    always_comb begin
        if (vs_rise_s && ((state_r == ST_WAIT_VS) || MODE)) begin
            crc_base_s = CRC_INIT;
        end else begin
            crc_base_s = crc_r;
        end
    end

    vid_crc_step #(
        .RGB_W    (RGB_W),
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY)
    ) u_crc_step (
        .crc_in  (crc_base_s),
        .data    (px_data_s),
        .crc_out (crc_step_s)
    );

    // Line-end geometry update; evaluated before any frame boundary on the
    // same CE so a closing line still belongs to the closing frame.
    always_comb begin
        line_n_s        = line_r;
        width_w_n_s     = width_w_r;
        width_valid_n_s = width_valid_r;
        err_w_n_s       = err_w_r;
        if (de_fall_s) begin
            line_n_s = sat_inc(line_r);
            if (!width_valid_r) begin
                width_w_n_s     = pix_r;
                width_valid_n_s = 1'b1;
            end else if (pix_r != width_w_r) begin
                err_w_n_s = 1'b1;
            end else begin
                err_w_n_s = err_w_r;
            end
        end else begin
            line_n_s = line_r;
        end
    end

    // Single-shot terminates once the frame count reaches max(NFRAMES, 1).
    always_comb begin
        fc_n_s = {1'b0, frame_cnt_r} + NF_ONE;
        if (NFRAMES == {NF_W{1'b0}}) begin
            target_s = NF_ONE;
        end else begin
            target_s = {1'b0, NFRAMES};
        end
        last_frame_s = (fc_n_s >= target_s);
    end

    // Capture sequencer with registered status and result outputs.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_r       <= ST_IDLE;
            vs_q_r        <= 1'b0;
            de_q_r        <= 1'b0;
            crc_r         <= {CRC_W{1'b0}};
            pix_r         <= CNT_ZERO;
            line_r        <= CNT_ZERO;
            width_w_r     <= CNT_ZERO;
            width_valid_r <= 1'b0;
            err_w_r       <= 1'b0;
            frame_cnt_r   <= {NF_W{1'b0}};
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            sig_r         <= {CRC_W{1'b0}};
            lines_r       <= CNT_ZERO;
            width_r       <= CNT_ZERO;
            err_r         <= 1'b0;
        end else begin
            if (CE) begin
                vs_q_r <= VS;
                de_q_r <= DE;
            end

            if (ARM) begin
                // ARM overrides any video event on the same cycle.
                state_r       <= ST_WAIT_VS;
                busy_r        <= 1'b1;
                done_r        <= 1'b0;
                err_r         <= 1'b0;
                frame_cnt_r   <= {NF_W{1'b0}};
                crc_r         <= CRC_INIT;
                pix_r         <= CNT_ZERO;
                line_r        <= CNT_ZERO;
                width_w_r     <= CNT_ZERO;
                width_valid_r <= 1'b0;
                err_w_r       <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                    end

                    ST_WAIT_VS: begin
                        if (vs_rise_s) begin
                            state_r       <= ST_CAPTURE;
                            frame_cnt_r   <= {NF_W{1'b0}};
                            line_r        <= CNT_ZERO;
                            width_w_r     <= CNT_ZERO;
                            width_valid_r <= 1'b0;
                            err_w_r       <= 1'b0;
                            crc_r         <= DE ? crc_step_s : CRC_INIT;
                            pix_r         <= DE ? CNT_ONE : CNT_ZERO;
                        end
                    end

                    ST_CAPTURE: begin
                        done_r <= 1'b0;
                        if (vs_rise_s) begin
                            lines_r       <= line_n_s;
                            width_r       <= width_w_n_s;
                            err_r         <= err_w_n_s;
                            frame_cnt_r   <= fc_n_s[NF_W-1:0];
                            line_r        <= CNT_ZERO;
                            width_w_r     <= CNT_ZERO;
                            width_valid_r <= 1'b0;
                            err_w_r       <= 1'b0;
                            if (!MODE && last_frame_s) begin
                                // The pixel on this CE, if any, is dropped.
                                sig_r   <= crc_r;
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                pix_r   <= CNT_ZERO;
                            end else begin
                                if (MODE) begin
                                    sig_r  <= crc_r;
                                    done_r <= 1'b1;
                                end
                                crc_r <= DE ? crc_step_s : crc_base_s;
                                pix_r <= DE ? CNT_ONE : CNT_ZERO;
                            end
                        end else begin
                            line_r        <= line_n_s;
                            width_w_r     <= width_w_n_s;
                            width_valid_r <= width_valid_n_s;
                            err_w_r       <= err_w_n_s;
                            if (de_fall_s) begin
                                pix_r <= CNT_ZERO;
                            end else if (CE && DE) begin
                                pix_r <= sat_inc(pix_r);
                                crc_r <= crc_step_s;
                            end else begin
                                pix_r <= pix_r;
                            end
                        end
                    end

                    ST_DONE: begin
                        busy_r <= 1'b0;
                    end

                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign BUSY  = busy_r;
    assign DONE  = done_r;
    assign SIG   = sig_r;
    assign LINES = lines_r;
    assign WIDTH = width_r;
    assign ERR   = err_r;

endmodule : vid_frame_sig

// File: tb/tb_vid_frame_sig.sv
// -----------------------------------------------------------------------------
// tb_vid_frame_sig
// Self-checking bench for vid_frame_sig: table of single-shot frame vectors,
// randomized geometry, and hand-written continuous / re-arm / reset sequences.
// Expected signatures come from a frame-level model: the list of masked pixels
// seen since capture start, folded through the CRC definition bit by bit.
// -----------------------------------------------------------------------------
module tb_vid_frame_sig;

    localparam int GAP = 7;

    logic        CLK = 1'b0;
    logic        RES, CE, DE, HS, VS, MODE, ARM;
    logic [23:0] RGB, CH_MASK;
    logic [3:0]  NFRAMES;
    logic        BUSY, DONE, ERR;
    logic [31:0] SIG;
    logic [9:0]  LINES, WIDTH;

    int errors = 0;
    int checks = 0;

    logic [23:0] pix_q[$];
    logic [31:0] exp_sigs[$];
    logic [31:0] got_sigs[$];
    bit          mon_en   = 1'b0;
    int          done_hi  = 0;
    int          busy_lo  = 0;

    typedef struct {
        int          nl;
        int          w0, w1, w2, w3;
        logic [23:0] mask;
        int          nf;
        bit          tight;
        int          exp_lines;
        int          exp_width;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    vid_frame_sig dut (
        .CLK(CLK), .RES(RES), .CE(CE), .DE(DE), .HS(HS), .VS(VS),
        .RGB(RGB), .CH_MASK(CH_MASK), .MODE(MODE), .ARM(ARM),
        .NFRAMES(NFRAMES), .BUSY(BUSY), .DONE(DONE), .SIG(SIG),
        .LINES(LINES), .WIDTH(WIDTH), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Continuous-mode observer: counts DONE-high cycles and BUSY-low cycles.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (DONE) begin
                done_hi++;
                got_sigs.push_back(SIG);
            end
            if (!BUSY) busy_lo++;
        end
    end

    // CRC over a pixel list from all-ones, MSB-first, no reflection/final XOR.
    function automatic logic [31:0] crc_frame(input logic [23:0] q[$]);
        logic [31:0] c;
        bit          fb;
        c = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            for (int b = 23; b >= 0; b--) begin
                fb = c[31] ^ q[k][b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic d, input logic [31:0] s,
                           input int l, input int w, input logic e);
        chk({tag, "_busy"},  {31'd0, BUSY}, {31'd0, b});
        chk({tag, "_done"},  {31'd0, DONE}, {31'd0, d});
        chk({tag, "_sig"},   SIG, s);
        chk({tag, "_lines"}, {22'd0, LINES}, l);
        chk({tag, "_width"}, {22'd0, WIDTH}, w);
        chk({tag, "_err"},   {31'd0, ERR}, {31'd0, e});
    endtask

    // One CE-qualified video sample followed by GAP-1 idle clocks.
    task automatic tick(input logic vs, input logic de, input logic [23:0] px);
        @(negedge CLK);
        CE = 1'b1; VS = vs; DE = de; RGB = px; HS = ~de;
        @(negedge CLK);
        CE = 1'b0;
        repeat (GAP - 1) @(negedge CLK);
    endtask

    task automatic blank();
        tick(1'b0, 1'b0, 24'h000000);
    endtask

    task automatic vs_pulse();
        tick(1'b1, 1'b0, 24'h000000);
        tick(1'b0, 1'b0, 24'h000000);
    endtask

    task automatic send_line(input int w, input bit rec);
        logic [23:0] px;
        for (int i = 0; i < w; i++) begin
            px = 24'($urandom);
            if (rec) pix_q.push_back(px & CH_MASK);
            tick(1'b0, 1'b1, px);
        end
    endtask

    task automatic arm();
        @(negedge CLK);
        ARM = 1'b1;
        @(negedge CLK);
        ARM = 1'b0;
    endtask

    // Single-shot capture of max(nf,1) identical-geometry frames, then checks.
    task automatic run_single(input string tag, input int nl, input int ws[4],
                              input logic [23:0] mask, input int nf, input bit tight,
                              input int el, input int ew, input bit ee);
        int          nfe;
        logic [31:0] esig;
        MODE = 1'b0; CH_MASK = mask; NFRAMES = 4'(nf);
        arm();
        vs_pulse();
        pix_q.delete();
        nfe = (nf == 0) ? 1 : nf;
        for (int f = 0; f < nfe; f++) begin
            for (int l = 0; l < nl; l++) begin
                send_line(ws[l], 1'b1);
                if (!(tight && (l == nl - 1))) blank();
            end
            vs_pulse();
        end
        esig = crc_frame(pix_q);
        chk_all(tag, 1'b0, 1'b1, esig, el, ew, ee);
        // Further video must not disturb the held result.
        send_line(2, 1'b0);
        blank();
        vs_pulse();
        chk({tag, "_hold_sig"}, SIG, esig);
    endtask

    initial begin
        int          ws[4];
        int          nl, ew;
        bit          ee;
        logic [23:0] px;

        vecs[0] = '{3, 4, 4, 4, 0, 24'hFFFFFF, 1, 1'b0, 3, 4, 1'b0};
        vecs[1] = '{3, 4, 5, 4, 0, 24'hFFFFFF, 1, 1'b0, 3, 4, 1'b1};
        vecs[2] = '{4, 2, 2, 2, 2, 24'h000000, 1, 1'b0, 4, 2, 1'b0};
        vecs[3] = '{3, 3, 3, 1, 0, 24'hFF0000, 1, 1'b0, 3, 3, 1'b1};
        vecs[4] = '{1, 6, 0, 0, 0, 24'hFFFFFF, 0, 1'b0, 1, 6, 1'b0};
        vecs[5] = '{0, 0, 0, 0, 0, 24'hFFFFFF, 1, 1'b0, 0, 0, 1'b0};
        vecs[6] = '{2, 4, 4, 0, 0, 24'h00FF0F, 3, 1'b0, 2, 4, 1'b0};
        vecs[7] = '{3, 2, 3, 3, 0, 24'hFFFFFF, 1, 1'b1, 3, 2, 1'b1};

        // Reset held two clocks during active video.
        RES = 1'b1; CE = 1'b1; DE = 1'b1; HS = 1'b0; VS = 1'b1; RGB = 24'h123456;
        CH_MASK = 24'hFFFFFF; MODE = 1'b0; ARM = 1'b0; NFRAMES = 4'd1;
        repeat (2) begin
            @(negedge CLK);
            VS = ~VS; RGB = 24'($urandom);
        end
        RES = 1'b0; CE = 1'b0; VS = 1'b0; DE = 1'b0;
        chk_all("reset", 1'b0, 1'b0, 32'h0, 0, 0, 1'b0);
        vs_pulse();
        send_line(4, 1'b0);
        blank();
        vs_pulse();
        chk_all("idle", 1'b0, 1'b0, 32'h0, 0, 0, 1'b0);

        // Table of single-shot frames.
        for (int i = 0; i < 8; i++) begin
            ws = '{vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3};
            run_single($sformatf("v%0d", i), vecs[i].nl, ws, vecs[i].mask, vecs[i].nf,
                       vecs[i].tight, vecs[i].exp_lines, vecs[i].exp_width, vecs[i].exp_err);
        end

        // Random geometry and masks; expectations from line-width rules.
        for (int r = 0; r < 4; r++) begin
            nl = $urandom_range(1, 4);
            for (int l = 0; l < 4; l++) ws[l] = $urandom_range(1, 5);
            ee = 1'b0;
            for (int l = 1; l < nl; l++) if (ws[l] != ws[0]) ee = 1'b1;
            ew = ws[0];
            run_single($sformatf("rnd%0d", r), nl, ws, 24'($urandom), 1,
                       1'($urandom_range(0, 1)), nl, ew, ee);
        end

        // Continuous mode: three frames, second one opened by VS with DE high.
        MODE = 1'b1; CH_MASK = 24'hFFFFFF;
        arm();
        mon_en = 1'b1;
        vs_pulse();
        pix_q.delete();
        exp_sigs.delete();
        for (int l = 0; l < 3; l++) begin send_line(3, 1'b1); blank(); end
        exp_sigs.push_back(crc_frame(pix_q));
        pix_q.delete();
        px = 24'($urandom);
        pix_q.push_back(px);
        tick(1'b1, 1'b1, px);
        send_line(3, 1'b1); blank();
        send_line(4, 1'b1); blank();
        exp_sigs.push_back(crc_frame(pix_q));
        pix_q.delete();
        vs_pulse();
        send_line(5, 1'b1); blank();
        exp_sigs.push_back(crc_frame(pix_q));
        pix_q.delete();
        vs_pulse();
        mon_en = 1'b0;
        chk("cont_done_cycles", done_hi, 3);
        chk("cont_busy_low", busy_lo, 0);
        chk("cont_sig_count", got_sigs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_sigs.size()) chk($sformatf("cont_sig%0d", i), got_sigs[i], exp_sigs[i]);
            else chk($sformatf("cont_sig%0d", i), 32'hxxxx_xxxx, exp_sigs[i]);
        end
        chk("cont_lines", {22'd0, LINES}, 1);
        chk("cont_width", {22'd0, WIDTH}, 5);

        // Re-arm mid-capture: only the frame after the second ARM counts.
        MODE = 1'b0; NFRAMES = 4'd1;
        arm();
        vs_pulse();
        send_line(3, 1'b0);
        arm();
        chk("rearm_busy", {31'd0, BUSY}, 1);
        chk("rearm_done", {31'd0, DONE}, 0);
        vs_pulse();
        pix_q.delete();
        for (int l = 0; l < 2; l++) begin send_line(2, 1'b1); blank(); end
        vs_pulse();
        chk_all("rearm", 1'b0, 1'b1, crc_frame(pix_q), 2, 2, 1'b0);

        // Reset mid-capture, then a clean capture.
        arm();
        vs_pulse();
        send_line(2, 1'b0);
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        chk_all("midres", 1'b0, 1'b0, 32'h0, 0, 0, 1'b0);
        RES = 1'b0;
        ws = '{3, 3, 0, 0};
        run_single("postres", 2, ws, 24'hFFFFFF, 1, 1'b0, 2, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vid_frame_sig
